// File: rtl/psram_pkg.sv
// Shared PSRAM QPI definitions: opcodes, address width
// and the write-engine state encoding.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 23;

  localparam logic [7:0] PSRAM_CMD_QWRITE  = 8'h38;
  localparam logic [7:0] PSRAM_CMD_QREAD   = 8'hEB;
  localparam logic [7:0] PSRAM_CMD_QPI_EN  = 8'h35;
  localparam logic [7:0] PSRAM_CMD_QPI_DIS = 8'hF5;
  localparam logic [7:0] PSRAM_CMD_RSTEN   = 8'h66;
  localparam logic [7:0] PSRAM_CMD_RST     = 8'h99;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CSOFF
  } psram_st_e;

endpackage

// File: rtl/psram_nibble_serializer.sv
// 16-bit load / 4-bit shift-out register with nibble index.
// nib_nxt is the nibble that will sit on top after this edge.
module psram_nibble_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] din,
  output logic [3:0]  nib_nxt,
  output logic [1:0]  idx
);

  logic [15:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= din;
      idx <= '0;
    end else if (shift) begin
      sr  <= {sr[11:0], 4'h0};
      idx <= idx + 2'd1;
    end
  end

  always_comb begin
    nib_nxt = sr[15:12];
    if (load)
      nib_nxt = din[15:12];
    else if (shift)
      nib_nxt = sr[11:8];
  end

endmodule

// File: rtl/psram_wrfifo_drain.sv
// QPI write engine: drains the write FIFO into fixed-length
// Quad Write (0x38) bursts at an auto-incrementing address.
module psram_wrfifo_drain
  import psram_pkg::*;
#(
  parameter int BURST_WORDS    = 16,
  parameter int CS_HIGH_CYCLES = 3,
  parameter int ADDR_W         = PSRAM_ADDR_W,
  parameter int USEDW_W        = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               addr_load,
  input  logic [ADDR_W-1:0]  addr_in,
  output logic               busy,
  output logic               burst_done,
  output logic [ADDR_W-1:0]  cur_addr,
  input  logic [15:0]        wrfifo_q,
  input  logic [USEDW_W-1:0] wrfifo_rdusedw,
  output logic               wrfifo_rdreq,
  output logic               psram_cs_n,
  output logic               psram_clk_en,
  output logic [3:0]         psram_sio_out,
  output logic               psram_sio_oe
);

  localparam int CNT_W =
    $clog2(4*BURST_WORDS + CS_HIGH_CYCLES + 8);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] DATA_LAST =
    CNT_W'(4*BURST_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_WORD =
    CNT_W'(4*(BURST_WORDS - 1));
  localparam logic [CNT_W-1:0] CSOFF_LAST =
    CNT_W'(CS_HIGH_CYCLES - 1);

  psram_st_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        start;
  logic [23:0] a24;
  logic [2:0]  a_sel;
  logic        ser_load, ser_shift;
  logic [3:0]  ser_nib;
  logic [1:0]  ser_idx;

  logic       cs_n_d, clk_en_d, oe_d;
  logic       rdreq_d, busy_d, done_d;
  logic [3:0] sio_d;

  assign start = !addr_load && enable &&
    (wrfifo_rdusedw >= USEDW_W'(BURST_WORDS));
  assign a24   = 24'(cur_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_CMD;
      ST_CMD:   if (cnt == CMD_LAST) state_nxt = ST_ADDR;
      ST_ADDR:  if (cnt == ADDR_LAST) state_nxt = ST_DATA;
      ST_DATA:  if (cnt == DATA_LAST) state_nxt = ST_CSOFF;
      ST_CSOFF: if (cnt == CSOFF_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state || state == ST_IDLE)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CNT_W'(1);
  end

  // Word k+1 loads on the last nibble of word k; word 0 on the last ADDR cycle.
  assign ser_load =
    (state == ST_ADDR && cnt == ADDR_LAST) ||
    (state == ST_DATA && ser_idx == 2'd3 && cnt < LAST_WORD);
  assign ser_shift = state == ST_DATA && ser_idx != 2'd3;

  psram_nibble_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (ser_load),
    .shift   (ser_shift),
    .din     (wrfifo_q),
    .nib_nxt (ser_nib),
    .idx     (ser_idx)
  );

  // Outputs are computed for the upcoming cycle and registered below.
  always_comb begin
    cs_n_d   = 1'b1;
    clk_en_d = 1'b0;
    oe_d     = 1'b0;
    sio_d    = 4'hF;
    rdreq_d  = 1'b0;
    busy_d   = state_nxt != ST_IDLE;
    done_d   = state == ST_CSOFF && state_nxt == ST_IDLE;
    a_sel    = 3'd5 - cnt_nxt[2:0];
    unique case (state_nxt)
      ST_CMD: begin
        cs_n_d   = 1'b0;
        clk_en_d = 1'b1;
        oe_d     = 1'b1;
        sio_d    = (state == ST_IDLE) ?
          PSRAM_CMD_QWRITE[7:4] : PSRAM_CMD_QWRITE[3:0];
        rdreq_d  = state == ST_IDLE;
      end
      ST_ADDR: begin
        cs_n_d   = 1'b0;
        clk_en_d = 1'b1;
        oe_d     = 1'b1;
        sio_d    = a24[{a_sel, 2'b00} +: 4];
      end
      ST_DATA: begin
        cs_n_d   = 1'b0;
        clk_en_d = 1'b1;
        oe_d     = 1'b1;
        sio_d    = ser_nib;
        rdreq_d  = state == ST_DATA && ser_idx == 2'd0 &&
          cnt < LAST_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psram_cs_n    <= 1'b1;
      psram_clk_en  <= 1'b0;
      psram_sio_oe  <= 1'b0;
      psram_sio_out <= 4'hF;
      wrfifo_rdreq  <= 1'b0;
      busy          <= 1'b0;
      burst_done    <= 1'b0;
    end else begin
      psram_cs_n    <= cs_n_d;
      psram_clk_en  <= clk_en_d;
      psram_sio_oe  <= oe_d;
      psram_sio_out <= sio_d;
      wrfifo_rdreq  <= rdreq_d;
      busy          <= busy_d;
      burst_done    <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cur_addr <= '0;
    else if (state == ST_IDLE && addr_load)
      cur_addr <= addr_in;
    else if (done_d)
      cur_addr <= cur_addr + ADDR_W'(2*BURST_WORDS);
  end

endmodule

// File: tb/tb_psram_wrfifo_drain.sv
// Bench for psram_wrfifo_drain: burst-timeline reference
// model checked every cycle under directed and random stimulus.
module tb_psram_wrfifo_drain;

  localparam int BW       = 16;
  localparam int CSH      = 3;
  localparam int AW       = 23;
  localparam int UW       = 10;
  localparam int CS_LOW   = 8 + 4*BW;
  localparam int BUSY_LEN = CS_LOW + CSH;
  localparam int MEM_N    = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [15:0]   wrfifo_q = '0;
  logic [UW-1:0] wrfifo_rdusedw = '0;
  logic          busy, burst_done, wrfifo_rdreq;
  logic [AW-1:0] cur_addr;
  logic          psram_cs_n, psram_clk_en, psram_sio_oe;
  logic [3:0]    psram_sio_out;

  psram_wrfifo_drain dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .addr_load      (addr_load),
    .addr_in        (addr_in),
    .busy           (busy),
    .burst_done     (burst_done),
    .cur_addr       (cur_addr),
    .wrfifo_q       (wrfifo_q),
    .wrfifo_rdusedw (wrfifo_rdusedw),
    .wrfifo_rdreq   (wrfifo_rdreq),
    .psram_cs_n     (psram_cs_n),
    .psram_clk_en   (psram_clk_en),
    .psram_sio_out  (psram_sio_out),
    .psram_sio_oe   (psram_sio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  logic [15:0] mem [MEM_N];
  int env_ptr = 0;
  bit prev_rd = 1'b0;

  int            m_rem = 0;
  bit            m_done = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_baddr = '0;
  int            m_wbase = 0;
  int            m_next = 0;
  int            rd_cnt = 0;
  int            cs_cnt = 0;
  int            done_cnt = 0;

  function automatic logic [3:0] exp_sio(int i);
    logic [7:0]  op;
    logic [23:0] a;
    logic [15:0] w;
    op = 8'h38;
    a  = 24'(m_baddr);
    if (i < 2)
      return (i == 0) ? op[7:4] : op[3:0];
    if (i < 8)
      return a[4*(7-i) +: 4];
    w = mem[(m_wbase + (i-8)/4) % MEM_N];
    return w[4*(3-(i-8)%4) +: 4];
  endfunction

  // Burst timeline: 2 CMD + 6 ADDR + 4*BW DATA with CS low, then CSH high.
  task automatic model_step();
    if (reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_addr = '0;
      m_next = env_ptr;
      rd_cnt = 0;
      cs_cnt = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
      if (m_done) m_addr = m_addr + AW'(2*BW);
    end else begin
      m_done = 1'b0;
      if (addr_load)
        m_addr = addr_in;
      else if (enable && wrfifo_rdusedw >= UW'(BW)) begin
        m_rem   = BUSY_LEN;
        m_baddr = m_addr;
        m_wbase = m_next;
        m_next += BW;
      end
    end
  endtask

  task automatic compare();
    int i;
    bit low;
    bit rd;
    logic [3:0] s;
    i   = BUSY_LEN - m_rem;
    low = m_rem > CSH;
    rd  = low && (i == 0 ||
          (i >= 8 && (i-8)%4 == 1 && (i-8)/4 < BW-1));
    s   = 4'hF;
    if (low) s = exp_sio(i);
    chk("cs_n", 32'(psram_cs_n), 32'(!low));
    chk("clk_en", 32'(psram_clk_en), 32'(low));
    chk("sio_oe", 32'(psram_sio_oe), 32'(low));
    chk("sio_out", 32'(psram_sio_out), 32'(s));
    chk("rdreq", 32'(wrfifo_rdreq), 32'(rd));
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("burst_done", 32'(burst_done), 32'(m_done));
    chk("cur_addr", 32'(cur_addr), 32'(m_addr));
    if (wrfifo_rdreq) rd_cnt++;
    if (!psram_cs_n) cs_cnt++;
    if (burst_done) done_cnt++;
    if (m_done) begin
      chk("rdreq_per_burst", 32'(rd_cnt), 32'(BW));
      chk("cs_low_len", 32'(cs_cnt), 32'(CS_LOW));
      rd_cnt = 0;
      cs_cnt = 0;
    end
  endtask

  task automatic env_step();
    if (prev_rd) begin
      wrfifo_q = mem[env_ptr % MEM_N];
      env_ptr++;
    end
    prev_rd = wrfifo_rdreq;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
    env_step();
  endtask

  task automatic reset_now();
    reset = 1'b1;
    #1;
    chk("rst_cs_n", 32'(psram_cs_n), 32'd1);
    chk("rst_clk_en", 32'(psram_clk_en), 32'd0);
    chk("rst_oe", 32'(psram_sio_oe), 32'd0);
    chk("rst_sio", 32'(psram_sio_out), 32'hF);
    chk("rst_rdreq", 32'(wrfifo_rdreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    prev_rd = 1'b0;
  endtask

  task automatic one_burst(int run);
    wrfifo_rdusedw = UW'(BW);
    tick();
    wrfifo_rdusedw = '0;
    repeat (run) tick();
  endtask

  initial begin
    int d0;
    logic [AW-1:0] a0;
    for (int k = 0; k < MEM_N; k++)
      mem[k] = (k < BW) ? 16'(16'h1234 + k) : 16'($urandom);

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // first burst, words 0x1234.. at address 0
    enable = 1'b1;
    wrfifo_rdusedw = UW'(20);
    tick();
    wrfifo_rdusedw = '0;
    repeat (80) tick();
    chk("addr_after_first", 32'(cur_addr), 32'h20);

    // one word short: no burst
    wrfifo_rdusedw = UW'(15);
    repeat (10) tick();
    chk("short_cs_n", 32'(psram_cs_n), 32'd1);
    one_burst(80);

    // load near the top of memory and wrap
    addr_load = 1'b1;
    addr_in = AW'(23'h7FFFE0);
    wrfifo_rdusedw = UW'(BW);
    tick();
    addr_load = 1'b0;
    chk("load_addr", 32'(cur_addr), 32'h7FFFE0);
    one_burst(80);
    chk("wrap_addr", 32'(cur_addr), 32'h0);

    // reset during DATA nibble 30
    one_burst(38);
    reset_now();
    tick();
    tick();
    reset = 1'b0;
    one_burst(80);

    // enable drops during ADDR
    wrfifo_rdusedw = UW'(BW);
    repeat (5) tick();
    enable = 1'b0;
    repeat (90) tick();
    chk("no_start_disabled", 32'(busy), 32'd0);

    // four back-to-back bursts
    a0 = m_addr;
    d0 = done_cnt;
    wrfifo_rdusedw = UW'(64);
    enable = 1'b1;
    repeat (4*76) tick();
    enable = 1'b0;
    repeat (4) tick();
    chk("four_bursts", 32'(done_cnt - d0), 32'd4);
    chk("addr_after4", 32'(cur_addr), 32'(a0 + AW'(8*BW)));

    // random traffic
    repeat (2000) begin
      tick();
      enable = $urandom_range(0, 3) != 0;
      wrfifo_rdusedw = UW'($urandom_range(0, 40));
      addr_load = $urandom_range(0, 15) == 0;
      addr_in = AW'($urandom);
      if (reset)
        reset = 1'b0;
      else if ($urandom_range(0, 599) == 0)
        reset_now();
    end
    reset = 1'b0;
    enable = 1'b0;
    addr_load = 1'b0;
    repeat (80) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
